// File: rtl/mux_scanner.sv
// mux_scanner: N-channel, W-bit multiplexer with a registered output.
// Three operating modes:
//   - Idle: the outputs freeze.
//   - Manual: the channel is chosen by SEL.
//   - Scan: the block steps through channels 0..CHANNELS-1 and stays DWELL cycles on each.
// Q always carries the data of the channel that CH reports.
//
// Ports:
//   clk    rising-edge system clock
//   rst    synchronous active-high reset; it overrides all other inputs
//   I      flattened inputs; channel k is I[k*WIDTH +: WIDTH]
//   SEL    manual channel select; values at or above CHANNELS are ignored
//   MODE   0 = manual, 1 = scan
//   EN     block enable; when low the block goes idle and the outputs hold
//   Q      registered data of the selected channel
//   CH     index of the channel presented on Q
//   VALID  one-cycle pulse when Q first presents a newly selected channel
//   WRAP   one-cycle pulse when the scan wraps from the last channel to channel 0
module mux_scanner #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DWELL    = 4,
    localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] I,
    input  logic [SEL_W-1:0]          SEL,
    input  logic                      MODE,
    input  logic                      EN,
    output logic [WIDTH-1:0]          Q,
    output logic [SEL_W-1:0]          CH,
    output logic                      VALID,
    output logic                      WRAP
);

    // The counter is kept at least 1 bit wide so that DWELL=1 still has a legal width.
    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned NSLOT = 1 << SEL_W;
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {StIdle, StManual, StScan} state_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;

    // The channel array is padded to a power of two. Any SEL value can then index it
    // safely, and the out-of-range entries are never loaded.
    logic [WIDTH-1:0] chan [NSLOT];

    for (genvar k = 0; k < NSLOT; k++) begin : g_chan
        if (k < CHANNELS) begin : g_used
            assign chan[k] = I[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign chan[k] = '0;
        end
    end

    logic             sel_ok;
    logic [SEL_W-1:0] nxt;

    always_comb begin
        sel_ok = (SEL <= LAST_CH);
        nxt    = (CH == LAST_CH) ? '0 : CH + SEL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
            cnt   <= '0;
            Q     <= '0;
            CH    <= '0;
            VALID <= 1'b0;
            WRAP  <= 1'b0;
        end else begin
            VALID <= 1'b0;
            WRAP  <= 1'b0;
            if (!EN) begin
                state <= StIdle;
                cnt   <= '0;
            end else if (!MODE) begin
                state <= StManual;
                cnt   <= '0;
                if (sel_ok) begin
                    Q     <= chan[SEL];
                    CH    <= SEL;
                    VALID <= (SEL != CH) || (state != StManual);
                end
            end else if (state != StScan) begin
                // Scan always starts at channel 0, whichever state it is entered from.
                state <= StScan;
                cnt   <= '0;
                CH    <= '0;
                Q     <= chan[0];
                VALID <= 1'b1;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                CH    <= nxt;
                Q     <= chan[nxt];
                VALID <= 1'b1;
                WRAP  <= (CH == LAST_CH);
            end else begin
                cnt <= cnt + CNT_W'(1);
                Q   <= chan[CH];
            end
        end
    end

endmodule
